// File: rtl/kernel_cc_wb_pkg.sv
`default_nettype none
// ============================================================================
// kernel_cc_wb_pkg : shared types and constants for the CC write-back stage
// Revision: 1.0
// ============================================================================
package kernel_cc_wb_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_ISSUE   = 2'd2,
        S_DONE    = 2'd3
    } wb_state_t;

    localparam int LANES      = 16;
    localparam int BEAT_BYTES = 64;
    localparam int STRB_W     = 64;
    localparam int BEAT_SHIFT = 6;

endpackage
`default_nettype wire

// File: rtl/kernel_cc_write_back_packer.sv
`default_nettype none
// ============================================================================
// kernel_cc_write_back_packer : lane register, lane index and byte strobes
// Revision: 1.0
// ============================================================================
module kernel_cc_write_back_packer
    import kernel_cc_wb_pkg::*;
#(
    parameter int LABEL_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [LABEL_W-1:0]         label,
    input  logic                       clear,
    output logic [LANES*LABEL_W-1:0]   data,
    output logic [LANES*LABEL_W/8-1:0] strb,
    output logic                       full
);

    localparam int IDX_W = $clog2(LANES);
    localparam int LB    = LABEL_W / 8;

    logic [IDX_W-1:0]         r_idx;
    logic [LANES*LABEL_W-1:0] r_data;
    logic [LANES*LB-1:0]      r_strb;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_data <= '0;
            r_strb <= '0;
        end else if (clear) begin
            r_idx  <= '0;
            r_data <= '0;
            r_strb <= '0;
        end else if (push) begin
            r_data[r_idx*LABEL_W +: LABEL_W] <= label;
            r_strb[r_idx*LB +: LB]           <= '1;
            r_idx                            <= r_idx + 1'b1;
        end
    end

    // Asserted while the next push lands in the last lane.
    assign full = (r_idx == IDX_W'(LANES - 1));
    assign data = r_data;
    assign strb = r_strb;

endmodule
`default_nettype wire

// File: rtl/kernel_cc_write_back.sv
`default_nettype none
// ============================================================================
// kernel_cc_write_back : packs the label stream into 512-bit write beats
// Revision: 1.0
// ============================================================================
module kernel_cc_write_back #(
    parameter int LABEL_W = 32,
    parameter int LANES   = 16,
    parameter int ADDR_W  = 64,
    parameter int CNT_W   = 32
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst_n,
    input  logic                       start_empty_n,
    output logic                       start_read,
    input  logic [ADDR_W-1:0]          base_addr,
    input  logic [CNT_W-1:0]           num_verts,
    input  logic [LABEL_W-1:0]         lab_dout,
    input  logic                       lab_empty_n,
    output logic                       lab_read,
    output logic                       wr_valid,
    input  logic                       wr_ready,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [LANES*LABEL_W-1:0]   wr_data,
    output logic [LANES*LABEL_W/8-1:0] wr_strb,
    output logic                       ap_idle,
    output logic                       ap_done
);

    import kernel_cc_wb_pkg::*;

    wb_state_t         r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_left;
    logic              r_wr_valid;
    logic              r_done;

    logic w_start_pop;
    logic w_lab_pop;
    logic w_accept;
    logic w_full;

    // Gating with the reset keeps both FIFOs untouched during the reset cycle.
    assign w_start_pop = ap_rst_n & (r_state == S_IDLE) & start_empty_n;
    assign w_lab_pop   = ap_rst_n & (r_state == S_COLLECT) & lab_empty_n & (r_left != '0);
    assign w_accept    = r_wr_valid & wr_ready;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_left     <= '0;
            r_wr_valid <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_start_pop) begin
                        r_addr <= {base_addr[ADDR_W-1:BEAT_SHIFT], {BEAT_SHIFT{1'b0}}};
                        r_left <= num_verts;
                        if (num_verts == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_COLLECT;
                        end
                    end
                end
                S_COLLECT: begin
                    if (w_lab_pop) begin
                        r_left <= r_left - 1'b1;
                        if (w_full || (r_left == CNT_W'(1))) begin
                            r_state    <= S_ISSUE;
                            r_wr_valid <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_accept) begin
                        r_addr     <= r_addr + ADDR_W'(BEAT_BYTES);
                        r_wr_valid <= 1'b0;
                        if (r_left == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_COLLECT;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    kernel_cc_write_back_packer #(
        .LABEL_W (LABEL_W)
    ) u_packer (
        .clk   (ap_clk),
        .rst_n (ap_rst_n),
        .push  (w_lab_pop),
        .label (lab_dout),
        .clear (w_start_pop | w_accept),
        .data  (wr_data),
        .strb  (wr_strb),
        .full  (w_full)
    );

    assign start_read = w_start_pop;
    assign lab_read   = w_lab_pop;
    assign wr_valid   = r_wr_valid;
    assign wr_addr    = r_addr;
    assign ap_done    = r_done;
    assign ap_idle    = (r_state == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_kernel_cc_write_back.sv
`default_nettype none
// ============================================================================
// tb_kernel_cc_write_back : job-table and directed-sequence bench
// Revision: 1.0
// ============================================================================
module tb_kernel_cc_write_back;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n;
    logic          start_empty_n;
    logic          start_read;
    logic [63:0]   base_addr;
    logic [31:0]   num_verts;
    logic [31:0]   lab_dout;
    logic          lab_empty_n;
    logic          lab_read;
    logic          wr_valid;
    logic          wr_ready;
    logic [63:0]   wr_addr;
    logic [511:0]  wr_data;
    logic [63:0]   wr_strb;
    logic          ap_idle;
    logic          ap_done;

    int total = 0;
    int bad   = 0;
    int unsigned lab_q[$];

    typedef struct {
        logic [63:0] base;
        int          num;
        int unsigned seed;
        bit          starve;
        int          stall;
        bit          pre_reset;
        int          exp_beats;
        int          exp_done;
        logic [63:0] exp_last_addr;
        logic [63:0] exp_last_strb;
    } job_t;

    job_t jobs[6];

    always #5 ap_clk = ~ap_clk;

    kernel_cc_write_back dut (
        .ap_clk        (ap_clk),
        .ap_rst_n      (ap_rst_n),
        .start_empty_n (start_empty_n),
        .start_read    (start_read),
        .base_addr     (base_addr),
        .num_verts     (num_verts),
        .lab_dout      (lab_dout),
        .lab_empty_n   (lab_empty_n),
        .lab_read      (lab_read),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_strb       (wr_strb),
        .ap_idle       (ap_idle),
        .ap_done       (ap_done)
    );

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic run_job(input int id, input job_t j);
        logic [63:0]  exp_addr, last_addr, last_strb, held_a;
        logic [511:0] exp_d, held_d;
        logic [63:0]  exp_s;
        int beat, popped, done_cyc, pulses, stall_left, gidx;
        bit stalled;
        lab_q.delete();
        for (int k = 0; k < j.num; k++) lab_q.push_back(j.seed + k);
        exp_addr  = {j.base[63:6], 6'b0};
        last_addr = '0;
        last_strb = '0;
        held_a = '0; held_d = '0;
        beat = 0; popped = 0; done_cyc = -1; pulses = 0; stall_left = j.stall; stalled = 0;
        @(negedge ap_clk);
        base_addr = j.base;
        num_verts = j.num;
        start_empty_n = 1'b1;
        for (int cyc = 0; cyc < 3000 && done_cyc < 0; cyc++) begin
            if (pulses > 0) start_empty_n = 1'b0;
            lab_empty_n = (lab_q.size() != 0) && (!j.starve || (cyc % 2 == 1));
            lab_dout    = (lab_q.size() != 0) ? lab_q[0] : 32'hDEAD_BEEF;
            wr_ready    = !(wr_valid && stall_left > 0);
            #1;
            if (start_read) pulses++;
            if (lab_read) begin
                chk($sformatf("j%0d lab_read_while_empty", id), lab_empty_n, 1'b1);
                popped++;
                if (lab_q.size() != 0) void'(lab_q.pop_front());
            end
            if (wr_valid) begin
                chk($sformatf("j%0d lab_read_in_issue", id), lab_read, 1'b0);
                if (!wr_ready) begin
                    if (stalled) begin
                        chk($sformatf("j%0d stall_data", id), wr_data, held_d);
                        chk($sformatf("j%0d stall_addr", id), wr_addr, held_a);
                    end
                    held_d = wr_data;
                    held_a = wr_addr;
                    stalled = 1;
                    stall_left--;
                end else begin
                    exp_d = '0;
                    exp_s = '0;
                    for (int l = 0; l < 16; l++) begin
                        gidx = beat * 16 + l;
                        if (gidx < j.num) begin
                            exp_d[l*32 +: 32] = j.seed + gidx;
                            exp_s[l*4 +: 4]   = 4'hF;
                        end
                    end
                    chk($sformatf("j%0d beat%0d addr", id, beat), wr_addr, exp_addr);
                    chk($sformatf("j%0d beat%0d data", id, beat), wr_data, exp_d);
                    chk($sformatf("j%0d beat%0d strb", id, beat), wr_strb, exp_s);
                    if (stalled) chk($sformatf("j%0d post_stall_data", id), wr_data, held_d);
                    last_addr = wr_addr;
                    last_strb = wr_strb;
                    exp_addr  = exp_addr + 64'd64;
                    beat++;
                end
            end
            if (ap_done) done_cyc = cyc;
            @(negedge ap_clk);
        end
        start_empty_n = 1'b0;
        lab_empty_n   = 1'b0;
        wr_ready      = 1'b1;
        #1;
        chk($sformatf("j%0d done_cycle", id), done_cyc, j.exp_done);
        chk($sformatf("j%0d beats", id), beat, j.exp_beats);
        chk($sformatf("j%0d labels_popped", id), popped, j.num);
        chk($sformatf("j%0d start_pulses", id), pulses, 1);
        chk($sformatf("j%0d last_addr", id), last_addr, j.exp_last_addr);
        chk($sformatf("j%0d last_strb", id), last_strb, j.exp_last_strb);
        chk($sformatf("j%0d done_one_cycle", id), ap_done, 1'b0);
        chk($sformatf("j%0d idle_after", id), ap_idle, 1'b1);
    endtask

    // Abandons a job mid-COLLECT by pulling reset with a token still waiting.
    task automatic mid_reset();
        lab_q.delete();
        for (int k = 0; k < 16; k++) lab_q.push_back(100 + k);
        @(negedge ap_clk);
        base_addr = 64'h6000;
        num_verts = 16;
        start_empty_n = 1'b1;
        wr_ready = 1'b1;
        @(negedge ap_clk);
        start_empty_n = 1'b0;
        for (int c = 0; c < 5; c++) begin
            lab_empty_n = 1'b1;
            lab_dout = lab_q[0];
            #1;
            if (lab_read) void'(lab_q.pop_front());
            @(negedge ap_clk);
        end
        ap_rst_n = 1'b0;
        start_empty_n = 1'b1;
        lab_empty_n = 1'b1;
        #1;
        chk("rst_mid start_read", start_read, 1'b0);
        chk("rst_mid lab_read", lab_read, 1'b0);
        @(negedge ap_clk);
        #1;
        chk("rst_mid wr_valid", wr_valid, 1'b0);
        chk("rst_mid wr_data", wr_data, '0);
        chk("rst_mid wr_strb", wr_strb, '0);
        chk("rst_mid wr_addr", wr_addr, '0);
        chk("rst_mid ap_done", ap_done, 1'b0);
        chk("rst_mid ap_idle", ap_idle, 1'b1);
        start_empty_n = 1'b0;
        lab_empty_n = 1'b0;
        ap_rst_n = 1'b1;
    endtask

    task automatic back_to_back();
        int tokens, npop, first_done;
        int pop_cyc[2];
        lab_q.delete();
        lab_q.push_back(32'hAA);
        tokens = 2; npop = 0; first_done = -1;
        pop_cyc[0] = -1; pop_cyc[1] = -1;
        @(negedge ap_clk);
        base_addr = 64'h7000;
        num_verts = 1;
        start_empty_n = 1'b1;
        wr_ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            lab_empty_n = (lab_q.size() != 0);
            lab_dout = (lab_q.size() != 0) ? lab_q[0] : 32'h0;
            #1;
            if (start_read) begin
                if (npop < 2) pop_cyc[npop] = cyc;
                npop++;
                tokens--;
            end
            if (lab_read && lab_q.size() != 0) void'(lab_q.pop_front());
            if (ap_done && first_done < 0) first_done = cyc;
            @(negedge ap_clk);
            if (npop == 1) begin
                base_addr = 64'h7100;
                num_verts = 0;
            end
            start_empty_n = (tokens > 0);
        end
        start_empty_n = 1'b0;
        lab_empty_n = 1'b0;
        chk("b2b pops", npop, 2);
        chk("b2b first_pop", pop_cyc[0], 0);
        chk("b2b first_done", first_done, 3);
        chk("b2b second_pop", pop_cyc[1], 4);
    endtask

    initial begin
        // base, num, seed, starve, stall, pre_reset, beats, done, last_addr, last_strb
        jobs[0] = '{64'h1000, 16, 0, 1'b0, 0, 1'b0, 1, 18, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFF};
        jobs[1] = '{64'h2030, 20, 32'h100, 1'b0, 0, 1'b0, 2, 23, 64'h2040, 64'h0000_0000_0000_FFFF};
        jobs[2] = '{64'h3000, 0, 0, 1'b0, 0, 1'b0, 0, 1, 64'h0, 64'h0};
        jobs[3] = '{64'h4000, 16, 32'h200, 1'b0, 5, 1'b0, 1, 23, 64'h4000, 64'hFFFF_FFFF_FFFF_FFFF};
        jobs[4] = '{64'h5000, 8, 32'h300, 1'b1, 0, 1'b0, 1, 17, 64'h5000, 64'h0000_0000_FFFF_FFFF};
        jobs[5] = '{64'hFFFF_FFFF_FFFF_FFC0, 32, 32'h500, 1'b0, 0, 1'b1, 2, 35, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF};

        ap_rst_n = 1'b0;
        start_empty_n = 1'b1;
        base_addr = '0;
        num_verts = '0;
        lab_dout = '0;
        lab_empty_n = 1'b1;
        wr_ready = 1'b1;
        repeat (3) @(negedge ap_clk);
        #1;
        chk("reset start_read", start_read, 1'b0);
        chk("reset lab_read", lab_read, 1'b0);
        chk("reset wr_valid", wr_valid, 1'b0);
        chk("reset wr_addr", wr_addr, '0);
        chk("reset wr_data", wr_data, '0);
        chk("reset wr_strb", wr_strb, '0);
        chk("reset ap_done", ap_done, 1'b0);
        chk("reset ap_idle", ap_idle, 1'b1);
        start_empty_n = 1'b0;
        lab_empty_n = 1'b0;
        ap_rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            if (jobs[i].pre_reset) mid_reset();
            run_job(i, jobs[i]);
        end

        back_to_back();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
